// File: rtl/mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// mod_sub_pipe
//
// Two-stage pipelined modular subtractor: c = (a - b) mod q for operands that
// are already reduced into [0, q). This is the subtract leg of a butterfly
// unit; the add leg is a separate combinational modular adder.
//
// Stage 1 registers the raw (W+1)-bit two's-complement difference and the
// modulus. Stage 2 applies a single conditional "+q" correction and holds the
// result on the output.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset (clears the valid flags and err_o)
//   in_valid_i   operand triple present
//   in_ready_o   block accepts the triple this cycle (combinational from out_ready_i)
//   a_i          minuend, expected < q_i
//   b_i          subtrahend, expected < q_i
//   q_i          modulus, captured together with a_i / b_i
//   out_valid_o  result present
//   out_ready_i  consumer takes the result this cycle
//   c_o          (a - b) mod q
//   err_o        sticky operand-range error
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side. A producer holds its payload and valid until it sees the
// transfer; ready may depend combinationally on the downstream ready, and valid
// never depends on ready.
//
// Optional feature (compile-time macro MOD_SUB_RANGE_CHECK_EN):
//   defined   -> each accepted triple with a_i >= q_i or b_i >= q_i sets err_o,
//                which stays set until rst_i. The result of such a triple is
//                meaningless, but the handshake is unaffected.
//   undefined -> no comparators are built and err_o is tied to 0.
// -----------------------------------------------------------------------------
module mod_sub_pipe #(
  parameter int W = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] c_o,
  output logic         err_o
);

  // Stage 1 state
  logic [W:0]   d1;   // {0,a} - {0,b}; the MSB is set when a < b
  logic [W-1:0] q1;
  logic         v1;

  // Stage 2 can take new contents whenever it is empty or being drained.
  logic s2_load;
  assign s2_load = !out_valid_o || out_ready_i;

  // Stage 1 can take a new triple when it is empty or moving on into stage 2.
  assign in_ready_o = !v1 || s2_load;

  // Correction: a borrow means the true difference lies in (-q, 0). Adding q
  // brings it into (0, q). That value fits in W bits, so the carry out of the
  // W-bit sum is dropped on purpose.
  logic [W-1:0] c_next;
  always_comb begin
    c_next = d1[W-1:0];
    if (d1[W]) begin
      c_next = d1[W-1:0] + q1;
    end
  end

  // Valid flags are the only pipeline state that is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1          <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (in_ready_o) begin
        v1 <= in_valid_i;
      end
      if (s2_load) begin
        out_valid_o <= v1;
      end
    end
  end

  // Data registers carry no reset. They only capture when a real transaction
  // moves, which keeps the data path quiet while the pipeline idles.
  always_ff @(posedge clk_i) begin
    if (in_ready_o && in_valid_i) begin
      d1 <= {1'b0, a_i} - {1'b0, b_i};
      q1 <= q_i;
    end
    if (s2_load && v1) begin
      c_o <= c_next;
    end
  end

`ifdef MOD_SUB_RANGE_CHECK_EN
  // Sticky flag: any accepted out-of-range operand sets it until reset.
  logic range_bad;
  assign range_bad = (a_i >= q_i) || (b_i >= q_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (in_valid_i && in_ready_o && range_bad) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_mod_sub_pipe
//
// Self-checking bench for mod_sub_pipe. Inputs are driven 1 time unit after
// the rising edge. A monitor samples on the falling edge, where it predicts
// accepts and consumes for the following rising edge. Accepted triples are
// turned into expected results by an independent model and queued, and every
// consumed result is compared in order.
// -----------------------------------------------------------------------------
module tb_mod_sub_pipe;

  localparam int W = 23;
  localparam logic [W-1:0] Q = 23'h7FE001;

`ifdef MOD_SUB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic         clk_i;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] q_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] c_o;
  logic         err_o;

  mod_sub_pipe #(.W(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .q_i         (q_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .c_o         (c_o),
    .err_o       (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           skip_q[$];   // 1 = result unspecified (out-of-range operand)
  logic         err_exp = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: (a - b) mod q, taking the branch on the comparison a >= b.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] q);
    int unsigned r;
    if (a >= b) r = int'(a) - int'(b);
    else        r = int'(a) + int'(q) - int'(b);
    return r[W-1:0];
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      err_exp = 1'b0;
    end else begin
      check("err_o", {{(W-1){1'b0}}, err_o}, {{(W-1){1'b0}}, err_exp});
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got c_o=%0d, expected no output", c_o);
        end else begin
          logic [W-1:0] e;
          bit           s;
          e = exp_q.pop_front();
          s = skip_q.pop_front();
          if (!s) check("scoreboard c_o", c_o, e);
        end
      end
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(model(a_i, b_i, q_i));
        skip_q.push_back((a_i >= q_i) || (b_i >= q_i));
        if (RANGE_EN && ((a_i >= q_i) || (b_i >= q_i))) err_exp = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    skip_q.delete();
    check("reset out_valid_o", {{(W-1){1'b0}}, out_valid_o}, '0);
    check("reset in_ready_o",  {{(W-1){1'b0}}, in_ready_o},  {{(W-1){1'b0}}, 1'b1});
    check("reset err_o",       {{(W-1){1'b0}}, err_o},       '0);
  endtask

  // Offers one triple and leaves in_valid_i high; returns the stall cycles seen.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                      output int stalls);
    bit done;
    done       = 1'b0;
    stalls     = 0;
    a_i        = a;
    b_i        = b;
    q_i        = q;
    in_valid_i = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (in_ready_o) done = 1'b1;
      else stalls++;
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready_o stayed 0 for 50 cycles, expected acceptance");
    end
  endtask

  // Single isolated transaction with out_ready_i high: checks the 2-cycle latency.
  task automatic run_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] exp);
    int st;
    out_ready_i = 1'b1;
    send(a, b, q, st);
    in_valid_i = 1'b0;
    check({name, " stall"}, st[W-1:0], '0);
    check({name, " valid@k"}, {{(W-1){1'b0}}, out_valid_o}, '0);
    tick();
    check({name, " valid@k+1"}, {{(W-1){1'b0}}, out_valid_o}, {{(W-1){1'b0}}, 1'b1});
    check({name, " c_o"}, c_o, exp);
    tick();
    check({name, " drained"}, {{(W-1){1'b0}}, out_valid_o}, '0);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] c;
  } vec_t;

  vec_t vecs[11];

  // ---------------- test sequence ----------------
  initial begin
    int st;
    int total_stalls;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    a_i = '0; b_i = '0; q_i = Q;

    vecs[0]  = '{"basic",          23'd5,       23'd3,       Q,           23'd2};
    vecs[1]  = '{"wrap",           23'd3,       23'd5,       Q,           23'h7FDFFF};
    vecs[2]  = '{"zero_minus_qm1", 23'd0,       23'h7FE000,  Q,           23'd1};
    vecs[3]  = '{"equal_qm1",      23'h7FE000,  23'h7FE000,  Q,           23'd0};
    vecs[4]  = '{"qm1_minus_zero", 23'h7FE000,  23'd0,       Q,           23'h7FE000};
    vecs[5]  = '{"zero_zero",      23'd0,       23'd0,       Q,           23'd0};
    vecs[6]  = '{"q2_0m1",         23'd0,       23'd1,       23'd2,       23'd1};
    vecs[7]  = '{"q2_1m0",         23'd1,       23'd0,       23'd2,       23'd1};
    vecs[8]  = '{"qmax_0m",        23'd0,       23'h7FFFFE,  23'h7FFFFF,  23'd1};
    vecs[9]  = '{"qmax_big",       23'h7FFFFE,  23'd1,       23'h7FFFFF,  23'h7FFFFD};
    vecs[10] = '{"q13_4m9",        23'd4,       23'd9,       23'd13,      23'd8};

    reset_dut();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_vector(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].c);
    end

    // Streaming: 1000 back-to-back random reduced triples, random modulus
    out_ready_i  = 1'b1;
    total_stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] q;
      q = W'($urandom_range(2, (1 << W) - 1));
      send(W'($urandom_range(0, int'(q) - 1)), W'($urandom_range(0, int'(q) - 1)), q, st);
      total_stalls += st;
    end
    in_valid_i = 1'b0;
    check("stream stalls", total_stalls[W-1:0], '0);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check("stream drain", exp_q.size() == 0 ? {{(W-1){1'b0}}, 1'b1} : '0, {{(W-1){1'b0}}, 1'b1});

    // Backpressure: capacity of two, third input held off, output frozen
    out_ready_i = 1'b0;
    send(23'd10, 23'd1, Q, st);
    send(23'd20, 23'd1, Q, st);
    a_i = 23'd30; b_i = 23'd1; q_i = Q; in_valid_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      check("bp in_ready_o",  {{(W-1){1'b0}}, in_ready_o},  '0);
      check("bp out_valid_o", {{(W-1){1'b0}}, out_valid_o}, {{(W-1){1'b0}}, 1'b1});
      check("bp c_o held",    c_o, 23'd9);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    check("bp release in_ready_o", {{(W-1){1'b0}}, in_ready_o}, {{(W-1){1'b0}}, 1'b1});
    tick();
    in_valid_i = 1'b0;
    check("bp second c_o", c_o, 23'd19);
    tick();
    check("bp third c_o", c_o, 23'd29);
    tick();
    check("bp drained", {{(W-1){1'b0}}, out_valid_o}, '0);

    // Reset with two transactions in flight
    out_ready_i = 1'b0;
    send(23'd50, 23'd2, Q, st);
    send(23'd60, 23'd3, Q, st);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    rst_i       = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    skip_q.delete();
    check("rst mid out_valid_o", {{(W-1){1'b0}}, out_valid_o}, '0);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("rst no stale", {{(W-1){1'b0}}, out_valid_o}, '0);
    end
    run_vector("post_reset", 23'd7, 23'd7, Q, 23'd0);

    // Range check: out-of-range minuend, then normal traffic, then reset
    send(Q, 23'd0, Q, st);
    in_valid_i = 1'b0;
    tick();
    tick();
    check("range err set", {{(W-1){1'b0}}, err_o}, {{(W-1){1'b0}}, RANGE_EN});
    run_vector("range_follow", 23'd9, 23'd4, Q, 23'd5);
    check("range err sticky", {{(W-1){1'b0}}, err_o}, {{(W-1){1'b0}}, RANGE_EN});
    reset_dut();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_sub_pipe.md
# mod_sub_pipe

Pipelined modular subtractor: computes c = (a − b) mod q for operands already reduced into [0, q), with q < 2^23. Counterpart of the combinational modular adder in the NTT/arith datapath. Pairs with it in butterfly units, where one leg adds and the other subtracts. It is a two-stage, valid/ready streaming block with full backpressure and one result per cycle sustained.

## Interface
Parameters:
- W, 23, operand/modulus width in bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand triple present.
- in_ready_o  out  1  block accepts the triple this cycle.
- a_i  in  W  minuend, must be < q_i.
- b_i  in  W  subtrahend, must be < q_i.
- q_i  in  W  modulus, sampled per transaction with a_i/b_i.
- out_valid_o  out  1  result present.
- out_ready_i  in  1  consumer takes the result this cycle.
- c_o  out  W  (a − b) mod q.
- err_o  out  1  sticky operand-range error; present only when the range-check macro is defined (see Configuration). Tie-off 0 otherwise.

## Operation
- Transfer rule: an input is accepted on an edge where in_valid_i && in_ready_o. An output is consumed on an edge where out_valid_o && out_ready_i.
- Stage 1 (S1) registers:
  - d1 = {1'b0,a_i} − {1'b0,b_i}, W+1 bits two's complement;
  - q1 = q_i;
  - v1.
- Stage 2 (S2, output) registers:
  - c_o = d1[W] ? d1[W−1:0] + q1 (mod 2^W) : d1[W−1:0];
  - out_valid_o.
- Correction arithmetic: when d1[W] = 1, the true difference is in (−q, 0). Adding q yields a value in (0, q). The W-bit truncated sum is exact, so no extra carry bit is kept.
- Advance logic:
  - s2_load = !out_valid_o || out_ready_i;
  - S2 loads S1 contents (including v1) when s2_load;
  - in_ready_o = !v1 || s2_load, a combinational path from out_ready_i;
  - S1 loads the input when in_ready_o. v1 takes in_valid_i on that edge.
- Holds:
  - Under stall (out_valid_o && !out_ready_i), c_o and out_valid_o stay constant.
  - If v1 is also set, S1 holds too and in_ready_o = 0.
- Ordering: strict FIFO. No reordering or dropping.
- Data registers (d1, q1, c_o) are not reset. Only the valid flags and err_o are.

## Timing
- Reset values: out_valid_o = 0, v1 = 0, err_o = 0. in_ready_o reads 1 in the first cycle after reset. c_o is don't-care until the first out_valid_o.
- Latency: a triple accepted at edge k appears with out_valid_o = 1 after edge k+1, i.e. 2 cycles with no stall.
- Throughput: 1 result per cycle while out_ready_i = 1.
- Capacity: at most 2 transactions in flight. With out_ready_i held low, exactly 2 inputs are accepted, then in_ready_o = 0.
- Simultaneous consume and accept in the same cycle: both happen. The pipeline stays full.
- Reset asserted mid-operation: all in-flight results are discarded. out_valid_o = 0 on the following cycle regardless of out_ready_i.
- Boundary cases:
  - a == b → 0.
  - a = 0, b = q−1 → 1.
  - a = q−1, b = 0 → q−1.

## Configuration
- Macro: MOD_SUB_RANGE_CHECK_EN.
- When defined:
  - on each accepted input, if a_i ≥ q_i or b_i ≥ q_i, err_o sets to 1 on that edge;
  - err_o stays 1 until rst_i;
  - c_o for that transaction is unspecified, but the handshake is unaffected.
- When not defined: no comparators are built and err_o is driven constant 0.

## Test plan
All scenarios use q = 8380417 (0x7FE001) unless stated otherwise.
- Basic: a=5, b=3, out_ready_i=1 → c_o=2, out_valid_o rises 2 cycles after acceptance.
- Wrap: a=3, b=5 → c_o=8380415 (0x7FDFFF). a=0, b=0x7FE000 → c_o=1. a=b=0x7FE000 → c_o=0.
- Streaming: 1000 random reduced triples, back-to-back with out_ready_i=1 → one result per cycle, matching a scoreboard in order. Also use random q ∈ [2, 2^23−1].
- Backpressure:
  - hold out_ready_i=0 while offering 3 inputs (a=10,20,30; b=1) → only 2 accepted, in_ready_o=0, c_o=9 held stable;
  - then release → outputs 9, 19, 29 in order, third input accepted.
- Reset mid-flight: assert rst_i for 1 cycle with 2 transactions in flight → out_valid_o=0 next cycle. No stale result emerges later. The next input a=7, b=7 yields c_o=0.
- Range check (macro defined): a=0x7FE001 (=q), b=0 → err_o=1 after the edge and stays 1 across further valid traffic until rst_i. With the macro undefined → err_o constantly 0.
